lcd_timing_gen: RTL and testbench

- Raster timing generator for the 800x480 LCD path; produces the Xpos/Ypos scan coordinates consumed by the pixel-generation blocks.
- Drives panel sync and data-enable strobes, delayed by a parameterised pipeline so they align with the registered RGB from downstream pixel logic.
- Adds frame-boundary start/stop control so the display never halts mid-frame.

---
 rtl/lcd_timing_pkg.sv | 20 ++
 rtl/lcd_timing_gen_if.sv | 41 ++++
 rtl/sync_delay_line.sv | 40 ++++
 rtl/lcd_timing_gen.sv | 137 +++++++++++++
 tb/tb_lcd_timing_gen.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing definitions for the 800x480 LCD path.
// Holds the generator FSM state type and the default raster timing constants
// used by the timing generator and by the downstream pixel generators.
package lcd_timing_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} tgen_state_t;

   localparam int unsigned H_ACTIVE = 800;
   localparam int unsigned H_FP     = 210;
   localparam int unsigned H_SYNC   = 30;
   localparam int unsigned H_BP     = 16;
   localparam int unsigned X_LIM    = H_ACTIVE + H_FP + H_SYNC + H_BP - 1;  // 1055

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 22;
   localparam int unsigned V_SYNC   = 13;
   localparam int unsigned V_BP     = 10;
   localparam int unsigned Y_LIM    = V_ACTIVE + V_FP + V_SYNC + V_BP - 1;  // 524

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Scan/strobe bundle between the LCD timing generator and its consumers.
//   run_req      : scan request level from the consumer side
//   Xpos, Ypos   : raster coordinates
//   line_start   : pulse at Xpos==0 while running
//   frame_start  : pulse at (0,0) while running
//   running      : generator is in RUN or DRAIN
//   hsync_n, vsync_n, de : delayed panel strobes
//   frame_cnt    : frame counter, present only with LCD_FRAME_CNT_EN
// modport master is the generator, modport slave the consumer.
interface lcd_timing_gen_if;

   logic        run_req;
   logic [10:0] Xpos;
   logic [9:0]  Ypos;
   logic        line_start;
   logic        frame_start;
   logic        running;
   logic        hsync_n;
   logic        vsync_n;
   logic        de;
`ifdef LCD_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   modport master (
      input  run_req,
      output Xpos, Ypos, line_start, frame_start, running, hsync_n, vsync_n, de
`ifdef LCD_FRAME_CNT_EN
      , output frame_cnt
`endif
   );

   modport slave (
      output run_req,
      input  Xpos, Ypos, line_start, frame_start, running, hsync_n, vsync_n, de
`ifdef LCD_FRAME_CNT_EN
      , input frame_cnt
`endif
   );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to align panel strobes with registered RGB.
//   clk   : pixel clock
//   reset : synchronous active-high reset, loads RESET_VAL into every stage
//   d_i   : undelayed strobes
//   q_o   : strobes delayed by DEPTH clocks (DEPTH=0 gives a combinational bypass)
module sync_delay_line #(
   parameter int unsigned          DEPTH     = 2,
   parameter int unsigned          WIDTH     = 3,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign q_o = d_i;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk) begin
         if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               stage_q[i] <= RESET_VAL;
            end
         end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the LCD path.
// Produces Xpos/Ypos scan coordinates, line/frame start pulses and the panel
// hsync_n/vsync_n/de strobes delayed by PIX_LATENCY clocks. Scanning starts
// on run_req and only stops at a frame boundary.
//   clk   : pixel clock
//   reset : synchronous active-high reset
//   tg    : lcd_timing_gen_if master (run_req in, scan/strobe outputs)
// Optional: define LCD_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE_P  = H_ACTIVE,
   parameter int unsigned H_FP_P      = H_FP,
   parameter int unsigned H_SYNC_P    = H_SYNC,
   parameter int unsigned H_BP_P      = H_BP,
   parameter int unsigned V_ACTIVE_P  = V_ACTIVE,
   parameter int unsigned V_FP_P      = V_FP,
   parameter int unsigned V_SYNC_P    = V_SYNC,
   parameter int unsigned V_BP_P      = V_BP,
   parameter int unsigned PIX_LATENCY = 2
) (
   input  logic            clk,
   input  logic            reset,
   lcd_timing_gen_if.master tg
);

   localparam logic [10:0] XLim     = 11'(H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
   localparam logic [9:0]  YLim     = 10'(V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P - 1);
   localparam logic [10:0] XAct     = 11'(H_ACTIVE_P);
   localparam logic [10:0] XHsStart = 11'(H_ACTIVE_P + H_FP_P);
   localparam logic [10:0] XHsEnd   = 11'(H_ACTIVE_P + H_FP_P + H_SYNC_P);
   localparam logic [9:0]  YAct     = 10'(V_ACTIVE_P);
   localparam logic [9:0]  YVsStart = 10'(V_ACTIVE_P + V_FP_P);
   localparam logic [9:0]  YVsEnd   = 10'(V_ACTIVE_P + V_FP_P + V_SYNC_P);

   tgen_state_t state_q;
   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        running_q;
   logic        frame_end;

   // Counter advance shared by RUN and DRAIN.
   always_comb begin
      frame_end = (x_q == XLim) && (y_q == YLim);
      x_d       = x_q + 11'd1;
      y_d       = y_q;
      if (x_q == XLim) begin
         x_d = '0;
         y_d = (y_q == YLim) ? '0 : y_q + 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         running_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               x_q <= '0;
               y_q <= '0;
               if (tg.run_req) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN, DRAIN: begin
               x_q <= x_d;
               y_q <= y_d;
               // A stop request only takes effect at the last pixel of a frame.
               if (tg.run_req) begin
                  state_q <= RUN;
               end else if (frame_end) begin
                  state_q   <= IDLE;
                  running_q <= 1'b0;
               end else begin
                  state_q <= DRAIN;
               end
            end
            default: begin
               state_q   <= IDLE;
               x_q       <= '0;
               y_q       <= '0;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   logic de_raw, hs_raw, vs_raw;
   logic [2:0] strobe_raw, strobe_dly;

   always_comb begin
      de_raw = running_q && (x_q < XAct) && (y_q < YAct);
      hs_raw = running_q && (x_q >= XHsStart) && (x_q < XHsEnd);
      vs_raw = running_q && (y_q >= YVsStart) && (y_q < YVsEnd);
   end

   assign strobe_raw = {~hs_raw, ~vs_raw, de_raw};

   sync_delay_line #(
      .DEPTH     (PIX_LATENCY),
      .WIDTH     (3),
      .RESET_VAL (3'b110)
   ) u_sync_delay_line (
      .clk   (clk),
      .reset (reset),
      .d_i   (strobe_raw),
      .q_o   (strobe_dly)
   );

   assign tg.Xpos        = x_q;
   assign tg.Ypos        = y_q;
   assign tg.running     = running_q;
   assign tg.line_start  = running_q && (x_q == '0);
   assign tg.frame_start = running_q && (x_q == '0) && (y_q == '0);
   assign tg.hsync_n     = strobe_dly[2];
   assign tg.vsync_n     = strobe_dly[1];
   assign tg.de          = strobe_dly[0];

`ifdef LCD_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
      end else if (tg.frame_start) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign tg.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen.
// dut_a uses a shrunken raster (15x10, PIX_LATENCY=0) so whole frames, drains
// and frame counting fit in a short run; dut_b uses the default 800x480 timing
// with the default latency of 2. Both share one randomized reset/run_req
// sequence and are compared every cycle against a position-based model.
module tb_lcd_timing_gen;

   logic clk;
   logic reset;

   lcd_timing_gen_if if_a ();
   lcd_timing_gen_if if_b ();

   lcd_timing_gen #(
      .H_ACTIVE_P  (8),
      .H_FP_P      (3),
      .H_SYNC_P    (2),
      .H_BP_P      (2),
      .V_ACTIVE_P  (5),
      .V_FP_P      (2),
      .V_SYNC_P    (2),
      .V_BP_P      (1),
      .PIX_LATENCY (0)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .tg    (if_a)
   );

   lcd_timing_gen dut_b (
      .clk   (clk),
      .reset (reset),
      .tg    (if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timing of each DUT, taken from the raster description, not the package.
   localparam int unsigned HA  [2] = '{8, 800};
   localparam int unsigned HF  [2] = '{3, 210};
   localparam int unsigned HS  [2] = '{2, 30};
   localparam int unsigned HB  [2] = '{2, 16};
   localparam int unsigned VA  [2] = '{5, 480};
   localparam int unsigned VF  [2] = '{2, 22};
   localparam int unsigned VS  [2] = '{2, 13};
   localparam int unsigned VB  [2] = '{1, 10};
   localparam int unsigned LAT [2] = '{0, 2};

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;

   // Model: linear pixel position within the frame plus a scanning flag.
   int unsigned pos  [2];
   bit          act  [2];
   logic [15:0] mcnt [2];
   logic [2:0]  hist [2][8];

   function automatic int unsigned line_len(input int d);
      return HA[d] + HF[d] + HS[d] + HB[d];
   endfunction

   function automatic int unsigned frame_len(input int d);
      return line_len(d) * (VA[d] + VF[d] + VS[d] + VB[d]);
   endfunction

   function automatic logic [2:0] raw_strobes(input int d);
      int unsigned x, y;
      bit de, hs, vs;
      x  = pos[d] % line_len(d);
      y  = pos[d] / line_len(d);
      de = act[d] && (x < HA[d]) && (y < VA[d]);
      hs = act[d] && (x >= HA[d] + HF[d]) && (x < HA[d] + HF[d] + HS[d]);
      vs = act[d] && (y >= VA[d] + VF[d]) && (y < VA[d] + VF[d] + VS[d]);
      return {~hs, ~vs, de};
   endfunction

   // Advance the model across one clock edge with the inputs seen at that edge.
   task automatic model_edge(input int d, input bit rst, input bit req);
      bit fs;
      if (rst) begin
         act[d]  = 1'b0;
         pos[d]  = 0;
         mcnt[d] = '0;
         for (int i = 0; i < 8; i++) hist[d][i] = 3'b110;
      end else begin
         fs = act[d] && (pos[d] == 0);
         if (fs) mcnt[d] = mcnt[d] + 16'd1;
         if (!act[d]) begin
            pos[d] = 0;
            if (req) act[d] = 1'b1;
         end else if (pos[d] == frame_len(d) - 1) begin
            pos[d] = 0;
            if (!req) act[d] = 1'b0;
         end else begin
            pos[d] = pos[d] + 1;
         end
         for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
      end
      hist[d][0] = raw_strobes(d);
   endtask

   task automatic chk(input string tag, input int d, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d cycle %0d: observed %0h expected %0h", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic check_dut(input int d, input logic [10:0] x, input logic [9:0] y,
                            input logic ls, input logic fs, input logic run,
                            input logic hs_n, input logic vs_n, input logic de);
      int unsigned ex, ey;
      logic [2:0]  s;
      ex = pos[d] % line_len(d);
      ey = pos[d] / line_len(d);
      s  = hist[d][LAT[d]];
      chk("Xpos", d, 32'(x), ex);
      chk("Ypos", d, 32'(y), ey);
      chk("running", d, 32'(run), 32'(act[d]));
      chk("line_start", d, 32'(ls), 32'(act[d] && ex == 0));
      chk("frame_start", d, 32'(fs), 32'(act[d] && pos[d] == 0));
      chk("hsync_n", d, 32'(hs_n), 32'(s[2]));
      chk("vsync_n", d, 32'(vs_n), 32'(s[1]));
      chk("de", d, 32'(de), 32'(s[0]));
   endtask

   task automatic step(input bit rst, input bit req);
      reset        = rst;
      if_a.run_req = req;
      if_b.run_req = req;
      @(posedge clk);
      cyc++;
      model_edge(0, rst, req);
      model_edge(1, rst, req);
      #1;
      check_dut(0, if_a.Xpos, if_a.Ypos, if_a.line_start, if_a.frame_start, if_a.running,
                if_a.hsync_n, if_a.vsync_n, if_a.de);
      check_dut(1, if_b.Xpos, if_b.Ypos, if_b.line_start, if_b.frame_start, if_b.running,
                if_b.hsync_n, if_b.vsync_n, if_b.de);
`ifdef LCD_FRAME_CNT_EN
      chk("frame_cnt", 0, 32'(if_a.frame_cnt), 32'(mcnt[0]));
      chk("frame_cnt", 1, 32'(if_b.frame_cnt), 32'(mcnt[1]));
`endif
   endtask

   task automatic run_for(input int n, input bit req);
      for (int i = 0; i < n; i++) step(1'b0, req);
   endtask

   initial begin
      reset        = 1'b1;
      if_a.run_req = 1'b0;
      if_b.run_req = 1'b0;
      for (int d = 0; d < 2; d++) begin
         pos[d]  = 0;
         act[d]  = 1'b0;
         mcnt[d] = '0;
         for (int i = 0; i < 8; i++) hist[d][i] = 3'b110;
      end

      // Reset state, then idle with run_req low: nothing may move.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      run_for(4, 1'b0);

      // Start scanning: three full small frames, and past the first default line wrap.
      run_for(3 * 150 + 1, 1'b1);
      run_for(1200, 1'b1);

      // Stop request mid-frame: small DUT drains to the frame end and idles.
      run_for(60, 1'b0);
      run_for(200, 1'b0);

      // Restart, then drop and re-raise run_req inside a drain.
      run_for(100, 1'b1);
      run_for(30, 1'b0);
      run_for(400, 1'b1);

      // Randomized run_req levels with random hold times.
      for (int k = 0; k < 40; k++) begin
         run_for(int'($urandom_range(1, 180)), 1'(($urandom_range(0, 3) != 0) ? 1 : 0));
      end

      // Reset while scanning, then resume.
      run_for(int'($urandom_range(20, 140)), 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      run_for(3, 1'b0);
      run_for(500, 1'b1);

      // Final stop: let the small DUT drain fully and the delay lines empty.
      run_for(400, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
